// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// Module   : debug_unit
// Brief    : UART command front-end: loads instruction memory, runs/steps the
//            pipeline and reports the PC. Optional PC report: DEBUG_PC_REPORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module debug_unit #(
    parameter int NB_INSTR           = 32,
    parameter int NB_REG             = 32,
    parameter int N_ADDR             = 512,
    parameter int LOG2_N_INSMEM_ADDR = $clog2(N_ADDR),
    parameter int NB_BYTE            = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NB_BYTE-1:0]            i_rx_data,
    input  logic                          i_rx_valid,
    input  logic                          i_halt,
    input  logic [NB_REG-1:0]             i_pc,
    input  logic                          i_tx_done,
    output logic                          o_imem_wr_en,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_INSTR-1:0]           o_imem_data,
    output logic                          o_pipe_valid,
    output logic                          o_pipe_reset,
    output logic [NB_BYTE-1:0]            o_tx_data,
    output logic                          o_tx_start
);

    localparam logic [NB_BYTE-1:0] c_cmd_load = 8'h4C;
    localparam logic [NB_BYTE-1:0] c_cmd_run  = 8'h52;
    localparam logic [NB_BYTE-1:0] c_cmd_step = 8'h53;
    localparam logic [NB_BYTE-1:0] c_cmd_halt = 8'h48;
`ifdef DEBUG_PC_REPORT_EN
    localparam logic [NB_BYTE-1:0] c_cmd_pc   = 8'h50;
`endif
    localparam logic [15:0]        c_n_addr   = 16'(N_ADDR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_LOAD   = 3'd3,
        S_WRITE  = 3'd4,
        S_RUN    = 3'd5,
        S_STEP   = 3'd6
`ifdef DEBUG_PC_REPORT_EN
        ,S_SEND  = 3'd7
`endif
    } state_t;

    state_t                          r_state;
    logic [15:0]                     r_len;
    logic [15:0]                     r_index;
    logic [NB_INSTR-NB_BYTE-1:0]     r_word;
    logic [1:0]                      r_byte_cnt;
    logic                            r_wr_en;
    logic [LOG2_N_INSMEM_ADDR-1:0]   r_addr;
    logic [NB_INSTR-1:0]             r_data;
    logic                            r_pipe_valid;
    logic                            r_pipe_reset;
`ifdef DEBUG_PC_REPORT_EN
    logic [NB_BYTE-1:0]              r_tx_data;
    logic                            r_tx_start;
    logic [NB_REG-1:0]               r_pc_shift;
    logic [1:0]                      r_tx_cnt;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_index      <= '0;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_reset <= 1'b1;
`ifdef DEBUG_PC_REPORT_EN
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_pc_shift   <= '0;
            r_tx_cnt     <= '0;
`endif
        end else begin
            r_wr_en      <= 1'b0;
            r_pipe_reset <= 1'b0;
`ifdef DEBUG_PC_REPORT_EN
            r_tx_start   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            c_cmd_load: r_state <= S_LEN_HI;
                            c_cmd_run: begin
                                r_state      <= S_RUN;
                                r_pipe_valid <= 1'b1;
                            end
                            c_cmd_step: begin
                                r_state      <= S_STEP;
                                r_pipe_valid <= 1'b1;
                            end
`ifdef DEBUG_PC_REPORT_EN
                            c_cmd_pc: begin
                                r_state    <= S_SEND;
                                r_tx_start <= 1'b1;
                                r_tx_data  <= i_pc[NB_REG-1 -: NB_BYTE];
                                r_pc_shift <= i_pc << NB_BYTE;
                                r_tx_cnt   <= '0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_LEN_HI: begin
                    if (i_rx_valid) begin
                        r_len[15:8] <= i_rx_data;
                        r_state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (i_rx_valid) begin
                        r_len[7:0] <= i_rx_data;
                        if (r_len[15:8] == 8'd0 && i_rx_data == 8'd0) begin
                            r_pipe_reset <= 1'b1;
                            r_index      <= '0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_byte_cnt <= '0;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_rx_valid) begin
                        if (r_byte_cnt == 2'd3) begin
                            // Words beyond the memory are consumed but never written
                            r_data     <= {r_word, i_rx_data};
                            r_wr_en    <= (r_index < c_n_addr);
                            if (r_index < c_n_addr)
                                r_addr <= r_index[LOG2_N_INSMEM_ADDR-1:0];
                            r_byte_cnt <= '0;
                            r_state    <= S_WRITE;
                        end else begin
                            r_word     <= {r_word[NB_INSTR-2*NB_BYTE-1:0], i_rx_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_index + 16'd1 == r_len) begin
                        r_pipe_reset <= 1'b1;
                        r_index      <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_index <= r_index + 16'd1;
                        r_state <= S_LOAD;
                        // A strobe overlapping the write cycle is the next word's first byte
                        if (i_rx_valid) begin
                            r_word     <= {r_word[NB_INSTR-2*NB_BYTE-1:0], i_rx_data};
                            r_byte_cnt <= 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (i_halt || (i_rx_valid && i_rx_data == c_cmd_halt)) begin
                        r_pipe_valid <= 1'b0;
`ifdef DEBUG_PC_REPORT_EN
                        r_state    <= S_SEND;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= i_pc[NB_REG-1 -: NB_BYTE];
                        r_pc_shift <= i_pc << NB_BYTE;
                        r_tx_cnt   <= '0;
`else
                        r_state    <= S_IDLE;
`endif
                    end
                end
                S_STEP: begin
                    r_pipe_valid <= 1'b0;
`ifdef DEBUG_PC_REPORT_EN
                    r_state    <= S_SEND;
                    r_tx_start <= 1'b1;
                    r_tx_data  <= i_pc[NB_REG-1 -: NB_BYTE];
                    r_pc_shift <= i_pc << NB_BYTE;
                    r_tx_cnt   <= '0;
`else
                    r_state    <= S_IDLE;
`endif
                end
`ifdef DEBUG_PC_REPORT_EN
                S_SEND: begin
                    if (i_tx_done) begin
                        if (r_tx_cnt == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tx_cnt   <= r_tx_cnt + 2'd1;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_pc_shift[NB_REG-1 -: NB_BYTE];
                            r_pc_shift <= r_pc_shift << NB_BYTE;
                        end
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_imem_wr_en = r_wr_en;
    assign o_imem_addr  = r_addr;
    assign o_imem_data  = r_data;
    assign o_pipe_valid = r_pipe_valid;
    assign o_pipe_reset = r_pipe_reset;

`ifdef DEBUG_PC_REPORT_EN
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
`else
    logic w_unused_tx;
    assign w_unused_tx = ^{i_pc, i_tx_done};
    assign o_tx_data   = '0;
    assign o_tx_start  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/debug_unit.md
# debug_unit

Front-end control stage for the MIPS pipeline. Receives command bytes from the UART receiver, loads a program into instruction memory, then runs the pipeline continuously or one cycle at a time by driving the pipeline's `i_valid` and `i_reset`. After a halt, a step or a query it sends the current PC back over the UART transmitter. It sits directly upstream of `pipeline` and owns its throughput-control input.

## Interface
- `NB_INSTR`, 32, instruction word width.
- `NB_REG`, 32, PC width.
- `N_ADDR`, 512, instruction memory depth in words.
- `LOG2_N_INSMEM_ADDR`, clogb2(N_ADDR), instruction memory address width.
- `NB_BYTE`, 8, UART data width.

Ports:
- `i_clock`  in  1  single clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  NB_BYTE  received byte; valid only while `i_rx_valid` is high.
- `i_rx_valid`  in  1  one-cycle strobe per received byte.
- `i_halt`  in  1  pipeline has retired a HALT instruction.
- `i_pc`  in  NB_REG  current pipeline PC.
- `i_tx_done`  in  1  one-cycle strobe when the UART transmitter has finished a byte.
- `o_imem_wr_en`  out  1  instruction memory write enable.
- `o_imem_addr`  out  LOG2_N_INSMEM_ADDR  word address.
- `o_imem_data`  out  NB_INSTR  word to write.
- `o_pipe_valid`  out  1  drives `pipeline.i_valid`.
- `o_pipe_reset`  out  1  drives `pipeline.i_reset`.
- `o_tx_data`  out  NB_BYTE  byte to transmit.
- `o_tx_start`  out  1  one-cycle transmit request.

## Operation
- States: IDLE, LEN_HI, LEN_LO, LOAD, WRITE, RUN, STEP, SEND.
- IDLE decodes the byte on `i_rx_valid`:
  - 0x4C 'L': go to LEN_HI.
  - 0x52 'R': go to RUN.
  - 0x53 'S': go to STEP.
  - 0x50 'P': go to SEND.
  - Any other byte is ignored.
- LEN_HI / LEN_LO: capture a 16-bit word count N, big-endian.
  - N=0 completes the load immediately.
  - Otherwise go to LOAD.
- LOAD: assemble 4 bytes big-endian into a word. The first byte goes to [31:24].
  - After the 4th byte, go to WRITE.
- WRITE lasts one cycle:
  - Drive `o_imem_wr_en`=1 with `o_imem_addr` = word index.
  - Increment the index.
  - If the index reaches N, load is complete; otherwise return to LOAD.
- Words with index ≥ N_ADDR are consumed, but `o_imem_wr_en` stays 0 for them. The address never wraps.
- Load complete: `o_pipe_reset`=1 for exactly one cycle, word index cleared, then IDLE.
- RUN: `o_pipe_valid`=1 every cycle until either:
  - `i_halt`=1 is sampled, or
  - byte 0x48 'H' arrives. All other bytes received in RUN are dropped.
  
  Then go to SEND.
- STEP: `o_pipe_valid`=1 for exactly one cycle, then SEND.
- SEND: capture `i_pc` on entry and transmit it as 4 bytes, MSB first.
  - Each byte: `o_tx_start`=1 for one cycle, then wait for `i_tx_done`.
  - After the 4th `i_tx_done`, go to IDLE.
  - Bytes received in SEND are dropped.

## Timing
- Reset values: state IDLE, word index 0, all outputs 0 except `o_pipe_reset`=1.
- `o_pipe_reset` is registered. It stays 1 while `i_reset` is high and falls on the first edge after release.
- All outputs are registered.
- Load path: `o_imem_wr_en` rises in the cycle after the 4th byte's `i_rx_valid` cycle. It is high for exactly 1 cycle.
- Load completion: the `o_pipe_reset` pulse follows the final write cycle directly. For N=0 it follows the LEN_LO byte cycle.
- RUN entry: `o_pipe_valid` rises in the cycle after the 'R' strobe cycle.
- RUN exit: `o_pipe_valid` falls in the cycle after `i_halt` (or the 'H' strobe) is sampled high. If both occur in the same cycle, the behaviour is identical.
- `o_pipe_valid` is never high outside RUN/STEP. `o_imem_wr_en` is never high outside WRITE.
- SEND: the first `o_tx_start` is in the first SEND cycle. Each subsequent start is in the cycle after the preceding `i_tx_done`.
- `i_tx_done` outside SEND is ignored.
- `i_reset` in any state, including mid-load, returns to IDLE next cycle:
  - partial word discarded;
  - index cleared;
  - `o_pipe_valid` and `o_tx_start` forced to 0.
- Back-to-back `i_rx_valid` on consecutive cycles must be accepted in LEN and LOAD. WRITE may coincide with the next byte's strobe; that byte must be captured.

## Configuration
- `DEBUG_PC_REPORT_EN` defined:
  - SEND exists as described;
  - 'P' is a valid command.
- `DEBUG_PC_REPORT_EN` undefined:
  - no SEND state;
  - RUN and STEP return directly to IDLE;
  - 'P' is ignored;
  - `o_tx_start` and `o_tx_data` are tied to 0;
  - `i_tx_done` and `i_pc` are unused.

## Test plan
- Load 2 words: 'L', 0x00, 0x02, then 0x20,0x01,0x00,0x05, 0x20,0x02,0x00,0x07.
  - Required: writes 0x20010005@0 and 0x20020007@1, one cycle each.
  - Required: then a 1-cycle `o_pipe_reset`.
- Run with halt: 'R', then assert `i_halt` 10 cycles later.
  - Required: `o_pipe_valid` high for exactly 10 cycles.
  - Required: then 4 TX bytes equal to `i_pc`=0x00000028, MSB first, each gated by `i_tx_done`.
- Step: 'S' with `i_pc`=0x4.
  - Required: `o_pipe_valid` high for exactly 1 cycle.
  - Required: TX 0x00,0x00,0x00,0x04.
- Reset mid-load: `i_reset` after 2 of 4 data bytes.
  - Required: no write.
  - Required: a following 1-word load writes to address 0.
- Oversize load: N=513.
  - Required: 512 writes at addresses 0..511, none for word 513.
  - Required: one `o_pipe_reset` pulse after the last word.
- Break: 'R', then 'H' with `i_halt`=0.
  - Required: `o_pipe_valid` drops in the cycle after the 'H' strobe.
  - Required: an unknown byte 0x7A in IDLE produces no output change.
